// File: rtl/core_pkg.sv
// core_pkg: shared register-file widths and arbiter defaults for the writeback arbiter
package core_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NREGS = 1 << REG_ADDR_W;
  localparam int LL_MAX_WAIT_DEFAULT = 4;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;
  function automatic int cnt_w(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/core_wb_scoreboard.sv
// core_wb_scoreboard: pending-destination vector for long-latency ops with three lookup ports
module core_wb_scoreboard
  import core_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en,
  input  reg_addr_t set_rd,
  input  logic      clr_en,
  input  reg_addr_t clr_rd,
  input  reg_addr_t lk_a,
  input  reg_addr_t lk_b,
  input  reg_addr_t lk_c,
  output logic      hit_a,
  output logic      hit_b,
  output logic      hit_c,
  output logic      busy
);
  logic [NREGS-1:0] pending, set_mask, clr_mask;
  always_comb begin
    set_mask = set_en ? (NREGS'(1) << set_rd) : '0;
    clr_mask = clr_en ? (NREGS'(1) << clr_rd) : '0;
  end
  // set applied after clear so a same-cycle reissue wins; x0 is never tracked
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else pending <= ((pending & ~clr_mask) | set_mask) & ~NREGS'(1);
  assign hit_a = pending[lk_a];
  assign hit_b = pending[lk_b];
  assign hit_c = pending[lk_c];
  assign busy = |pending;
endmodule

// File: rtl/core_wb_arb.sv
// core_wb_arb: regfile write-port arbiter (pipeline vs long-latency unit) with hazard scoreboard
// CORE_WB_ARB_BYPASS_EN adds rs1_fwd/rs2_fwd same-cycle forwarding of the LL write
module core_wb_arb
  import core_pkg::*;
#(
  parameter int LL_MAX_WAIT = LL_MAX_WAIT_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      pipe_we,
  input  reg_addr_t pipe_rd,
  input  xlen_t     pipe_wdata,
  output logic      pipe_stall,
  input  logic      ll_valid,
  output logic      ll_ready,
  input  reg_addr_t ll_rd,
  input  xlen_t     ll_wdata,
  input  logic      ll_issue,
  input  reg_addr_t ll_issue_rd,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rd_chk,
  output logic      hazard,
  output logic      ll_busy,
  output logic      rf_we,
  output reg_addr_t rf_rd,
  output xlen_t     rf_wdata
`ifdef CORE_WB_ARB_BYPASS_EN
  ,
  output logic      rs1_fwd,
  output logic      rs2_fwd
`endif
);
  localparam int CW = cnt_w(LL_MAX_WAIT);
  localparam logic [CW-1:0] MAXC = CW'(LL_MAX_WAIT);
  logic [CW-1:0] wait_cnt;
  logic starve, grant_ll, hit1, hit2, hitd, fwd1, fwd2;
  always_comb begin
    starve = wait_cnt == MAXC;
    grant_ll = ll_valid & (~pipe_we | starve);
    ll_ready = grant_ll;
    pipe_stall = pipe_we & grant_ll;
    rf_rd = grant_ll ? ll_rd : pipe_rd;
    rf_wdata = grant_ll ? ll_wdata : pipe_wdata;
    rf_we = (grant_ll | pipe_we) & (rf_rd != '0);
  end
  // counts consecutive cycles an offered LL result is refused
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= '0;
    else wait_cnt <= (~ll_valid | grant_ll) ? '0 : starve ? wait_cnt : wait_cnt + CW'(1);
  core_wb_scoreboard u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (ll_issue),
    .set_rd (ll_issue_rd),
    .clr_en (grant_ll),
    .clr_rd (ll_rd),
    .lk_a   (rs1),
    .lk_b   (rs2),
    .lk_c   (rd_chk),
    .hit_a  (hit1),
    .hit_b  (hit2),
    .hit_c  (hitd),
    .busy   (ll_busy)
  );
`ifdef CORE_WB_ARB_BYPASS_EN
  assign fwd1 = grant_ll & (ll_rd == rs1) & (rs1 != '0);
  assign fwd2 = grant_ll & (ll_rd == rs2) & (rs2 != '0);
  assign rs1_fwd = fwd1;
  assign rs2_fwd = fwd2;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  assign hazard = (hit1 & ~fwd1) | (hit2 & ~fwd2) | hitd;
endmodule
